k12_nonce_scheduler: RTL and testbench

- Sequences one K12_Hash core across a nonce range for a single mining job.
- Latches a 1600-bit work state and a 64-bit target, splices each nonce into the state, pulses the core's start, and waits for its valid.
- Compares the top hash word to the target and reports winning nonces through a ready/valid port.
- Sits between the host/UART job loader and the K12_Hash instance.

---
 rtl/k12_pkg.sv | 25 ++
 rtl/k12_nonce_splice.sv | 19 +
 rtl/k12_nonce_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_k12_nonce_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k12_pkg.sv
// Shared definitions for the K12 nonce scheduler: FSM state encoding,
// state/hash geometry and the winning-hash compare.
package k12_pkg;

  localparam int K12_STATE_W = 1600;
  localparam int HASH_CMP_HI = 255;
  localparam int HASH_CMP_LO = 192;
  localparam int NONCE_W     = 32;
  localparam int HASH_WORD_W = HASH_CMP_HI - HASH_CMP_LO + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_REPORT
  } k12_state_e;

  // A hash wins only when strictly below the target (unsigned).
  function automatic logic hash_wins(input logic [HASH_WORD_W-1:0] word,
                                     input logic [HASH_WORD_W-1:0] target);
    return word < target;
  endfunction

endpackage

// File: rtl/k12_nonce_splice.sv
// Drops the current nonce into the latched work-state template,
// nonce LSB at bit NONCE_OFFSET (little-endian byte order).
module k12_nonce_splice
  import k12_pkg::*;
#(
  parameter int NONCE_OFFSET = 312
) (
  input  logic [K12_STATE_W-1:0] tmpl,
  input  logic [NONCE_W-1:0]     nonce,
  output logic [K12_STATE_W-1:0] data
);

  // Template everywhere except the nonce field.
  always_comb begin
    data                          = tmpl;
    data[NONCE_OFFSET +: NONCE_W] = nonce;
  end

endmodule

// File: rtl/k12_nonce_scheduler.sv
// Drives one K12_Hash core across an inclusive nonce range for a single job
// and reports nonces whose top hash word is below the target.
// Optional watchdog on the WAIT state: define K12_WATCHDOG_EN.
module k12_nonce_scheduler
  import k12_pkg::*;
#(
  parameter int NONCE_OFFSET = 312,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   work_valid,
  input  logic [K12_STATE_W-1:0] work_data,
  input  logic [HASH_WORD_W-1:0] work_target,
  input  logic [NONCE_W-1:0]     nonce_first,
  input  logic [NONCE_W-1:0]     nonce_last,
  input  logic                   abort,
  output logic                   k12_start,
  output logic [K12_STATE_W-1:0] k12_data,
  input  logic [255:0]           k12_hash,
  input  logic                   k12_valid,
  output logic                   found_valid,
  output logic [NONCE_W-1:0]     found_nonce,
  output logic [HASH_WORD_W-1:0] found_hash,
  input  logic                   found_ready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            hash_count,
  output logic                   wd_error
);

  k12_state_e             state_q, state_d;
  logic [K12_STATE_W-1:0] tmpl_q, tmpl_d;
  logic [HASH_WORD_W-1:0] target_q, target_d;
  logic [HASH_WORD_W-1:0] hash_word_q, hash_word_d;
  logic [NONCE_W-1:0]     nonce_q, nonce_d;
  logic [NONCE_W-1:0]     last_q, last_d;
  logic [31:0]            hash_count_q, hash_count_d;
  logic [3:0]             start_cnt_q, start_cnt_d;
  logic                   abort_q, abort_d;
  logic                   done_q, done_d;
`ifdef K12_WATCHDOG_EN
  logic [15:0]            wd_cnt_q, wd_cnt_d;
  logic                   wd_error_q, wd_error_d;
`endif

  // Only the top hash word takes part in the compare.
  logic unused_hash_lo;
  assign unused_hash_lo = ^k12_hash[HASH_CMP_LO-1:0];

  k12_nonce_splice #(.NONCE_OFFSET(NONCE_OFFSET)) u_splice (
    .tmpl  (tmpl_q),
    .nonce (nonce_q),
    .data  (k12_data)
  );

  assign k12_start   = (state_q == ST_START);
  assign busy        = (state_q != ST_IDLE);
  // An abort in REPORT withdraws the winner in the same cycle.
  assign found_valid = (state_q == ST_REPORT) && !abort;
  assign found_nonce = nonce_q;
  assign found_hash  = hash_word_q;
  assign done        = done_q;
  assign hash_count  = hash_count_q;
`ifdef K12_WATCHDOG_EN
  assign wd_error    = wd_error_q;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign wd_error    = 1'b0;
`endif

  // Next-state logic: job load, start burst, result capture, compare, report.
  always_comb begin
    state_d      = state_q;
    tmpl_d       = tmpl_q;
    target_d     = target_q;
    hash_word_d  = hash_word_q;
    nonce_d      = nonce_q;
    last_d       = last_q;
    hash_count_d = hash_count_q;
    start_cnt_d  = start_cnt_q;
    abort_d      = abort_q;
    done_d       = 1'b0;
`ifdef K12_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    wd_error_d   = wd_error_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (work_valid) begin
          tmpl_d       = work_data;
          target_d     = work_target;
          nonce_d      = nonce_first;
          last_d       = nonce_last;
          hash_count_d = '0;
          abort_d      = 1'b0;
`ifdef K12_WATCHDOG_EN
          wd_error_d   = 1'b0;
`endif
          state_d      = ST_START;
        end
      end
      ST_START: begin
        // The core has been started, so an abort must wait for its result.
        abort_d = abort_q | abort;
        if (start_cnt_q == 4'(START_CYCLES - 1)) begin
          state_d = ST_WAIT;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      ST_WAIT: begin
        abort_d = abort_q | abort;
        if (k12_valid) begin
          hash_count_d = hash_count_q + 32'd1;
          if (abort_q || abort) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hash_word_d = k12_hash[HASH_CMP_HI:HASH_CMP_LO];
            state_d     = ST_CHECK;
          end
        end
`ifdef K12_WATCHDOG_EN
        else if (wd_cnt_q == 16'(TIMEOUT - 1)) begin
          wd_error_d = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      ST_CHECK, ST_REPORT: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_CHECK && hash_wins(hash_word_q, target_q)) begin
          state_d = ST_REPORT;
        end else if (state_q == ST_CHECK || found_ready) begin
          if (nonce_q == last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every fresh START begins a new burst and a new watchdog window.
    if (state_d == ST_START && state_q != ST_START) begin
      start_cnt_d = '0;
`ifdef K12_WATCHDOG_EN
      wd_cnt_d    = '0;
`endif
    end
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tmpl_q       <= '0;
      target_q     <= '0;
      hash_word_q  <= '0;
      nonce_q      <= '0;
      last_q       <= '0;
      hash_count_q <= '0;
      start_cnt_q  <= '0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
`ifdef K12_WATCHDOG_EN
      wd_cnt_q     <= '0;
      wd_error_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tmpl_q       <= tmpl_d;
      target_q     <= target_d;
      hash_word_q  <= hash_word_d;
      nonce_q      <= nonce_d;
      last_q       <= last_d;
      hash_count_q <= hash_count_d;
      start_cnt_q  <= start_cnt_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
`ifdef K12_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      wd_error_q   <= wd_error_d;
`endif
    end
  end

endmodule

// File: tb/tb_k12_nonce_scheduler.sv
// Scoreboard bench for k12_nonce_scheduler with a stub K12 core.
// Watchdog scenario compiled in with K12_WATCHDOG_EN.
module tb_k12_nonce_scheduler;
  import k12_pkg::*;

  localparam int OFF = 312;
  localparam int SC  = 4;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          work_valid = 1'b0;
  logic [1599:0] work_data = '0;
  logic [63:0]   work_target = '0;
  logic [31:0]   nonce_first = '0, nonce_last = '0;
  logic          abort = 1'b0;
  logic          k12_start;
  logic [1599:0] k12_data;
  logic [255:0]  k12_hash = '0;
  logic          k12_valid = 1'b0;
  logic          found_valid;
  logic [31:0]   found_nonce;
  logic [63:0]   found_hash;
  logic          found_ready = 1'b0;
  logic          busy, done, wd_error;
  logic [31:0]   hash_count;

  k12_nonce_scheduler #(.NONCE_OFFSET(OFF), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .work_data(work_data),
    .work_target(work_target), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .abort(abort), .k12_start(k12_start), .k12_data(k12_data), .k12_hash(k12_hash),
    .k12_valid(k12_valid), .found_valid(found_valid), .found_nonce(found_nonce),
    .found_hash(found_hash), .found_ready(found_ready), .busy(busy), .done(done),
    .hash_count(hash_count), .wd_error(wd_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Environment: stub core behaviour and expectations
  typedef struct { logic [31:0] n; logic [63:0] h; } found_t;
  logic [31:0]   exp_start_q[$];
  found_t        exp_found_q[$];
  logic [31:0]   exp_count = 0;
  bit            chk_count = 1'b0;
  bit            wd_expect = 1'b0;
  bit            abort_expect = 1'b0;
  logic [1599:0] tmpl_cur = '0;
  int            ready_delay = 0;

  bit            mute = 1'b0, spurious = 1'b0, hash_rand = 1'b0;
  int            lat_min = 0, lat_max = 4;
  logic [31:0]   sp_nonce = 0, seed = 0;
  logic [63:0]   hw_default = '1, hw_special = '1;

  function automatic logic [63:0] ref_hash(input logic [31:0] n);
    if (hash_rand) return {(n * 32'h9E3779B1) ^ seed, n ^ 32'h5A5A5A5A};
    return (n == sp_nonce) ? hw_special : hw_default;
  endfunction

  function automatic logic [1599:0] ref_data(input logic [1599:0] t, input logic [31:0] n);
    logic [1599:0] m;
    m = {{1568{1'b0}}, 32'hFFFF_FFFF} << OFF;
    return (t & ~m) | ({1568'b0, n} << OFF);
  endfunction

  // Reference: every nonce of the inclusive (possibly wrapping) range is
  // hashed once, in order; winners are those strictly below the target.
  task automatic model_job(input logic [31:0] first, input logic [31:0] last,
                           input logic [63:0] target);
    logic [31:0] cnt, n;
    cnt = last - first + 32'd1;
    n   = first;
    for (int unsigned i = 0; i < cnt; i++) begin
      exp_start_q.push_back(n);
      if (ref_hash(n) < target) exp_found_q.push_back('{n, ref_hash(n)});
      n = n + 32'd1;
    end
    exp_count = cnt;
    chk_count = 1'b1;
  endtask

  // Stub core: captures the nonce at the start burst, answers after a delay
  initial begin : stub
    logic [31:0] n;
    int k;
    forever begin
      @(negedge clk); #1;
      if (rst && k12_start) begin
        n = k12_data[OFF +: 32];
        k = 0;
        while (k12_start) begin
          @(negedge clk); #1;
          k++;
          k12_hash  = '0;
          k12_valid = spurious && (k == 1);
        end
        k12_valid = 1'b0;
        if (!mute) begin
          repeat ($urandom_range(lat_max, lat_min)) begin @(negedge clk); #1; end
          k12_hash[255:192] = ref_hash(n);
          for (int w = 0; w < 6; w++) k12_hash[w*32 +: 32] = $urandom();
          k12_valid = 1'b1;
          @(negedge clk); #1;
          k12_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations as the DUT presents starts, winners and done
  int          cyc = 0, done_seen = 0, fall_cyc = 0, last_valid_cyc = -100;
  int          start_len = 0, fv_cycles = 0;
  bit          prev_start = 0, accept_pending = 0, data_unstable = 0, found_unstable = 0;
  logic [1599:0] start_data = '0;
  logic [31:0] held_n = 0;
  logic [63:0] held_h = 0;

  always @(negedge clk) begin
    logic [31:0] en;
    found_t f;
    cyc++;
    if (!rst) begin
      prev_start = 0; fv_cycles = 0; accept_pending = 0; found_ready = 0;
      data_unstable = 0; found_unstable = 0;
    end else begin
      if (accept_pending) begin
        check("found_valid_drops_after_accept", found_valid, 0);
        accept_pending = 0;
      end
      if (k12_start && !prev_start) begin
        if (exp_start_q.size() == 0) begin
          fail("unexpected_start", $sformatf("nonce %h", k12_data[OFF +: 32]));
        end else begin
          en = exp_start_q.pop_front();
          check("start_nonce", k12_data[OFF +: 32], en);
          checks++;
          if (k12_data !== ref_data(tmpl_cur, en)) begin
            errors++;
            $display("FAIL k12_data: template bits outside nonce field differ (nonce %h expected %h)",
                     k12_data[OFF +: 32], en);
          end
        end
        start_len  = 1;
        start_data = k12_data;
      end else if (k12_start) begin
        start_len++;
      end
      if (!k12_start && prev_start) begin
        check("start_burst_len", start_len, SC);
        fall_cyc = cyc;
      end
      prev_start = k12_start;
      if (busy && k12_data !== start_data) data_unstable = 1;
      if (k12_valid) last_valid_cyc = cyc;

      if (found_valid) begin
        if (fv_cycles == 0) begin
          held_n = found_nonce; held_h = found_hash;
        end else if (found_nonce !== held_n || found_hash !== held_h) begin
          found_unstable = 1;
        end
        fv_cycles++;
        if (!found_ready && fv_cycles > ready_delay) begin
          found_ready = 1'b1;
          if (exp_found_q.size() == 0) begin
            fail("unexpected_found", $sformatf("nonce %h hash %h", found_nonce, found_hash));
          end else begin
            f = exp_found_q.pop_front();
            check("found_nonce", found_nonce, f.n);
            check("found_hash", found_hash, f.h);
          end
          check("found_held_stable", found_unstable, 0);
          accept_pending = 1;
        end
      end else begin
        fv_cycles = 0; found_ready = 1'b0; found_unstable = 0;
      end

      if (done) begin
        done_seen++;
        check("done_without_found_valid", found_valid, 0);
        check("busy_at_done", busy, 0);
        if (chk_count) check("hash_count", hash_count, exp_count);
        check("starts_outstanding", exp_start_q.size(), 0);
        check("winners_outstanding", exp_found_q.size(), 0);
        check("k12_data_stable", data_unstable, 0);
        data_unstable = 0;
        // A k12_valid seen at this sample was consumed by the preceding edge.
        if (abort_expect) check("abort_done_latency", cyc - last_valid_cyc, 0);
        if (wd_expect) begin
          check("wd_error", wd_error, 1);
          check("wd_done_latency", cyc - fall_cyc, TO);
        end else begin
          check("wd_error", wd_error, 0);
        end
      end
    end
  end

  // Stimulus
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) fail("idle_timeout", "DUT stayed busy");
  endtask

  task automatic load_job(input logic [31:0] first, input logic [31:0] last,
                          input logic [63:0] target, input int delay);
    logic [1599:0] t;
    wait_idle();
    for (int w = 0; w < 50; w++) t[w*32 +: 32] = $urandom();
    tmpl_cur    = t;
    ready_delay = delay;
    model_job(first, last, target);
    @(negedge clk);
    work_data = t; work_target = target; nonce_first = first; nonce_last = last;
    work_valid = 1'b1;
    @(negedge clk);
    work_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start, n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < 20000) begin @(negedge clk); n++; end
    if (done_seen == start) fail("done_timeout", "no done pulse");
    repeat (3) @(negedge clk);
    check("single_done", done_seen - start, 1);
  endtask

  initial begin
    logic [63:0] t;
    logic [31:0] first;
    #23;
    check("rst_busy", busy, 0);
    check("rst_k12_start", k12_start, 0);
    check("rst_done", done, 0);
    check("rst_found_valid", found_valid, 0);
    check("rst_hash_count", hash_count, 0);
    check("rst_k12_data", {63'b0, |k12_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Plain range, no winners, spurious valid during START must be ignored
    hw_default = '1; spurious = 1'b1;
    load_job(32'h10, 32'h13, 64'h0, 0);
    wait_done();
    spurious = 1'b0;

    // Single winner under 10 cycles of backpressure
    sp_nonce = 32'h12; hw_special = 64'h0000_00FF_FFFF_FFFF;
    load_job(32'h10, 32'h13, 64'h0000_0100_0000_0000, 10);
    wait_done();

    // Equality is not a win; one below is
    t = {$urandom(), $urandom()} | 64'h1;
    sp_nonce = 32'h77; hw_special = t;
    load_job(32'h77, 32'h77, t, 2);
    wait_done();
    hw_special = t - 64'h1;
    load_job(32'h77, 32'h77, t, 2);
    wait_done();

    // Range across the 32-bit wrap
    load_job(32'hFFFF_FFFE, 32'h0000_0001, 64'h0, 0);
    wait_done();

    // Randomized jobs; work_valid while busy must be ignored
    hash_rand = 1'b1; lat_max = 6;
    for (int j = 0; j < 6; j++) begin
      seed  = $urandom();
      first = $urandom();
      load_job(first, first + 32'($urandom_range(5, 0)), {$urandom(), $urandom()},
               $urandom_range(4, 0));
      repeat (2) @(negedge clk);
      nonce_first = ~first; work_valid = 1'b1;
      @(negedge clk);
      work_valid = 1'b0;
      wait_done();
    end
    hash_rand = 1'b0; lat_max = 4;

    // Abort during WAIT: in-flight hash finishes and is discarded
    hw_default = 64'h0; lat_min = 20; lat_max = 20;
    load_job(32'h40, 32'h50, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    exp_start_q.delete(); exp_start_q.push_back(32'h40);
    exp_found_q.delete(); chk_count = 1'b0; abort_expect = 1'b1;
    while (!k12_start) @(negedge clk);
    while (k12_start) @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done();
    abort_expect = 1'b0; lat_min = 0; lat_max = 4; hw_default = '1;

    // Asynchronous reset between clock edges while in WAIT
    mute = 1'b1;
    load_job(32'h5, 32'h9, 64'h0, 0);
    while (!k12_start) @(negedge clk);
    while (k12_start) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_k12_start", k12_start, 0);
    check("arst_k12_data", {63'b0, |k12_data}, 0);
    check("arst_found_nonce", found_nonce, 0);
    check("arst_found_hash", found_hash, 0);
    check("arst_hash_count", hash_count, 0);
    check("arst_done", done, 0);
    check("arst_wd_error", wd_error, 0);
    exp_start_q.delete(); exp_found_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef K12_WATCHDOG_EN
    // Stub never answers: watchdog ends the job
    load_job(32'h100, 32'h100, 64'h0, 0);
    exp_count = 0; wd_expect = 1'b1;
    wait_done();
    wd_expect = 1'b0;
`endif

    // Normal job after reset / watchdog clears the error flag
    mute = 1'b0;
    load_job(32'h20, 32'h21, 64'h0, 0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
